multicycle_control: RTL

- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback across the shared ALU, register file, memory port and immediate extender.
- Drives the immediate extender's mode select: sign-extend for lw/sw/beq/addi, zero-extend for andi/ori.
- Waits on a memory-ready handshake and flags stalled memory accesses.

---
 rtl/multicycle_control.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback.
// Optional macro MC_ILLEGAL_TRAP_EN parks unknown opcodes in TRAP(12) until reset.
module multicycle_control #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       ext_zero,
    output logic [1:0] pc_src,
    output logic [3:0] state,
    output logic       timeout
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
`ifdef MC_ILLEGAL_TRAP_EN
        , S_TRAP = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_next;
    logic       r_timeout;
    logic       w_mem_state;
    logic       w_next_mem_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_wait_cnt_next >= LIMIT) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:               w_next = S_MEMADR;
                    OP_R:                       w_next = S_EXEC;
                    OP_BEQ:                     w_next = S_BEQ;
                    OP_J:                       w_next = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI:   w_next = S_IEXEC;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:                    w_next = S_TRAP;
`else
                    default:                    w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  if (mem_ready) w_next = S_FETCH;
            S_EXEC:   w_next = S_RWB;
            S_RWB:    w_next = S_FETCH;
            S_BEQ:    w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_IEXEC:  w_next = S_IWB;
            S_IWB:    w_next = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:   w_next = S_TRAP;
`endif
            default:  w_next = S_FETCH;
        endcase
    end

    // Counter restarts only when a memory state is newly entered, not while holding in it.
    assign w_mem_state      = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_next_mem_state = (w_next == S_FETCH) || (w_next == S_MEMRD) || (w_next == S_MEMWR);

    always_comb begin
        w_wait_cnt_next = r_wait_cnt;
        if ((w_next != r_state) && w_next_mem_state) begin
            w_wait_cnt_next = 8'd0;
        end else if (w_mem_state && !mem_ready && (r_wait_cnt != 8'hFF)) begin
            w_wait_cnt_next = r_wait_cnt + 8'd1;
        end
    end

    // Strobes are forced low while reset is held so nothing completes mid-instruction.
    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        ext_zero   = 1'b0;
        pc_src     = 2'b00;
        if (reset_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                end
                S_DECODE: alu_src_b = 2'b11;
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_src    = 2'b01;
                    pc_en     = zero;
                end
                S_JUMP: begin
                    pc_src = 2'b10;
                    pc_en  = 1'b1;
                end
                S_IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (opcode)
                        OP_ANDI: begin
                            alu_op   = 2'b10;
                            ext_zero = 1'b1;
                        end
                        OP_ORI: begin
                            alu_op   = 2'b11;
                            ext_zero = 1'b1;
                        end
                        default: alu_op = 2'b00;
                    endcase
                end
                S_IWB: begin
                    reg_write = 1'b1;
                    ext_zero  = (opcode == OP_ANDI) || (opcode == OP_ORI);
                end
                default: ;
            endcase
        end
    end

    assign state   = r_state;
    assign timeout = r_timeout;

endmodule
